reg_snapshot_mgr: RTL and testbench

REG_SNAPSHOT_MGR -- requirements
Module: reg_snapshot_mgr

---
 rtl/snapshot_pkg.sv | 18 +
 rtl/snapshot_ram.sv | 40 ++++
 rtl/reg_snapshot_mgr.sv | 160 ++++++++++++++++
 tb/tb_reg_snapshot_mgr.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snapshot_pkg.sv
// Shared definitions for the register-file checkpoint manager.
//   DATA_WIDTH    : width of one architectural register (matches the core datapath)
//   NUM_REGS      : architectural registers captured per checkpoint
//   DEFAULT_DEPTH : default number of checkpoint slots
//   snap_state_e  : recovery FSM states
package snapshot_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned NUM_REGS      = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRecover,
    StWaitDone
  } snap_state_e;

endpackage

// File: rtl/snapshot_ram.sv
// Checkpoint slot storage: DEPTH slots, each a full copy of the register file.
// One synchronous write port (whole slot at once) and one asynchronous read port.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write enable for slot i_wr_addr
//   i_wr_addr  : slot written on the rising edge
//   i_wr_data  : register-file image to store
//   i_rd_addr  : slot read combinationally
//   o_rd_data  : register-file image held in slot i_rd_addr
module snapshot_ram
  import snapshot_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data [NUM_REGS],
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0]        o_rd_data [NUM_REGS]
);

  // Storage is intentionally not reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH][NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i_wr_addr][i] <= i_wr_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      o_rd_data[i] = r_mem[i_rd_addr][i];
    end
  end

endmodule

// File: rtl/reg_snapshot_mgr.sv
// Register-file checkpoint manager for branch speculation.
// Each decoded branch captures the live register file into a circular FIFO of
// checkpoints; branches resolve in program order. A correct resolve retires the
// oldest checkpoint, a mispredict restores the oldest checkpoint to the register
// file via a one-cycle recover_snapshot command and flushes all younger ones.
// Optional feature: define SNAPSHOT_WB_BYPASS_EN to merge a same-cycle write-back
// into the captured image (r0 is never bypassed).
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_take_snapshot              : branch decoded, capture a checkpoint
//   i_regs_in                    : live register file contents
//   i_wb_uses_rw/_rw_addr/_data  : same-cycle write-back
//   i_resolve_valid/_mispredict  : oldest outstanding branch resolved / mispredicted
//   i_done                       : register file restore complete
//   o_recover_snapshot           : one-cycle restore command
//   o_regs_snapshot              : registered checkpoint image for restore
//   o_snap_ready                 : a slot is free and no recovery is in progress
//   o_busy                       : recovery in progress
//   o_count                      : outstanding checkpoints
module reg_snapshot_mgr
  import snapshot_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_take_snapshot,
  input  logic [DATA_WIDTH-1:0]     i_regs_in [NUM_REGS],
  input  logic                      i_wb_uses_rw,
  input  logic [4:0]                i_wb_rw_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_rw_data,
  input  logic                      i_resolve_valid,
  input  logic                      i_resolve_mispredict,
  input  logic                      i_done,
  output logic                      o_recover_snapshot,
  output logic [DATA_WIDTH-1:0]     o_regs_snapshot [NUM_REGS],
  output logic                      o_snap_ready,
  output logic                      o_busy,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  snap_state_e           r_state;
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [CntW-1:0]       r_count;
  logic                  r_recover;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_regs_snapshot [NUM_REGS];

  logic                  w_idle;
  logic                  w_has_entry;
  logic                  w_full;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_capture   [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_head_data [NUM_REGS];

  assign w_idle      = (r_state == StIdle);
  assign w_has_entry = (r_count != '0);
  assign w_full      = (r_count == CntW'(DEPTH));
  assign w_flush     = w_idle & i_resolve_valid & i_resolve_mispredict & w_has_entry;
  assign w_pop       = w_idle & i_resolve_valid & ~i_resolve_mispredict & w_has_entry;
  // A mispredict in the same cycle squashes the new branch, so its take is dropped.
  assign w_push      = w_idle & i_take_snapshot & ~w_full & ~w_flush;

`ifdef SNAPSHOT_WB_BYPASS_EN
  // The write-back lands in the register file on this same edge, so fold it in.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_capture[i] = i_regs_in[i];
      if (i_wb_uses_rw && (i_wb_rw_addr != 5'd0) && (i_wb_rw_addr == 5'(i))) begin
        w_capture[i] = i_wb_rw_data;
      end
    end
  end
`else
  logic w_wb_unused;
  assign w_wb_unused = ^{i_wb_uses_rw, i_wb_rw_addr, i_wb_rw_data};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_capture[i] = i_regs_in[i];
    end
  end
`endif

  snapshot_ram #(
    .DEPTH (DEPTH)
  ) u_snapshot_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_tail),
    .i_wr_data (w_capture),
    .i_rd_addr (r_head),
    .o_rd_data (w_head_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_recover <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs_snapshot[i] <= '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (w_flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              r_regs_snapshot[i] <= w_head_data[i];
            end
            r_head    <= r_tail;
            r_count   <= '0;
            r_state   <= StRecover;
            r_recover <= 1'b1;
            r_busy    <= 1'b1;
          end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop) begin
              r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        StRecover: begin
          r_recover <= 1'b0;
          r_state   <= StWaitDone;
        end
        StWaitDone: begin
          if (i_done) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_recover <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_recover_snapshot = r_recover;
  assign o_regs_snapshot    = r_regs_snapshot;
  assign o_busy             = r_busy;
  assign o_count            = r_count;
  assign o_snap_ready       = ~w_full & w_idle;

endmodule

// File: tb/tb_reg_snapshot_mgr.sv
// Scoreboard bench for reg_snapshot_mgr. The reference model keeps checkpoints
// in a queue of flattened register images and a three-phase recovery counter;
// each mispredict pushes the expected restore image, which a separate monitor
// pops whenever the DUT pulses recover_snapshot.
module tb_reg_snapshot_mgr;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [32*32-1:0] flat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        take;
  logic [31:0] regs_in [32];
  logic        wbu;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        rv;
  logic        rm;
  logic        dn;
  logic        rec;
  logic [31:0] snap [32];
  logic        ready;
  logic        busy;
  logic [CW-1:0] cnt;

  // Staged values applied together with the next step's controls.
  logic [31:0] nx_regs [32];
  logic        nx_wbu;
  logic [4:0]  nx_wa;
  logic [31:0] nx_wd;

  int    n_checks = 0;
  int    n_fail   = 0;
  flat_t slots[$];
  flat_t exp_q[$];
  flat_t last_snap;
  int    phase;
  bit    model_ok = 1'b0;

  always #5 clk = ~clk;

  reg_snapshot_mgr #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_take_snapshot      (take),
    .i_regs_in            (regs_in),
    .i_wb_uses_rw         (wbu),
    .i_wb_rw_addr         (wa),
    .i_wb_rw_data         (wd),
    .i_resolve_valid      (rv),
    .i_resolve_mispredict (rm),
    .i_done               (dn),
    .o_recover_snapshot   (rec),
    .o_regs_snapshot      (snap),
    .o_snap_ready         (ready),
    .o_busy               (busy),
    .o_count              (cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic flat_t pack_snap();
    flat_t f;
    for (int i = 0; i < 32; i++) f[i*32 +: 32] = snap[i];
    return f;
  endfunction

  task automatic check_image(input string name, input flat_t act, input flat_t exp);
    bit shown;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      shown = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (!shown && act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL %s: r%0d got %0h, expected %0h", name, i, act[i*32 +: 32],
                   exp[i*32 +: 32]);
          shown = 1'b1;
        end
      end
    end
  endtask

  // Image the model expects to be captured from the currently applied inputs.
  function automatic flat_t capture();
    flat_t f;
    for (int i = 0; i < 32; i++) f[i*32 +: 32] = regs_in[i];
`ifdef SNAPSHOT_WB_BYPASS_EN
    if (wbu && wa != 5'd0) f[int'(wa)*32 +: 32] = wd;
`endif
    return f;
  endfunction

  task automatic step(input bit t, input bit v, input bit m, input bit d, input bit r);
    @(negedge clk);
    if (model_ok) begin
      check("count", 64'(cnt), 64'(slots.size()));
      check("snap_ready", 64'(ready), 64'(phase == 0 && slots.size() < DEPTH));
      check("busy", 64'(busy), 64'(phase != 0));
      check("recover_snapshot", 64'(rec), 64'(phase == 1));
      check_image("regs_snapshot_hold", pack_snap(), last_snap);
    end
    for (int i = 0; i < 32; i++) regs_in[i] = nx_regs[i];
    wbu = nx_wbu; wa = nx_wa; wd = nx_wd;
    rst = r; take = t; rv = v; rm = m; dn = d;
    if (r) begin
      slots.delete();
      phase     = 0;
      last_snap = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      case (phase)
        0: begin
          bit    mis;
          bit    pop;
          bit    push;
          flat_t c;
          c    = capture();
          mis  = v && m && slots.size() > 0;
          pop  = v && !m && slots.size() > 0;
          push = t && slots.size() < DEPTH && !mis;
          if (mis) begin
            last_snap = slots[0];
            exp_q.push_back(slots[0]);
            slots.delete();
            phase = 1;
          end else begin
            if (pop) void'(slots.pop_front());
            if (push) slots.push_back(c);
          end
        end
        1: phase = 2;
        default: if (d) phase = 0;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every restore pulse must match the oldest expected image.
  always @(negedge clk) begin
    if (model_ok && rec === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL recover_pulse: got unexpected pulse, expected none");
      end else begin
        check_image("restore_image", pack_snap(), exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; take = 1'b0; wbu = 1'b0; wa = '0; wd = '0; rv = 1'b0; rm = 1'b0; dn = 1'b0;
    nx_wbu = 1'b0; nx_wa = '0; nx_wd = '0;
    for (int i = 0; i < 32; i++) begin
      regs_in[i] = '0;
      nx_regs[i] = 32'h100 + i;
    end

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Take then correct resolve: count 1 then 0, no restore.
    nx_regs[5] = 32'h1234;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(2);

    // Two takes, mispredict restores the older one; done two cycles later.
    nx_regs[5] = 32'hA;
    step(1, 0, 0, 0, 0);
    nx_regs[5] = 32'hB;
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(2);

    // Five takes into four slots; head data must survive.
    for (int k = 0; k < 5; k++) begin
      nx_regs[5] = 32'h50 + k;
      step(1, 0, 0, 0, 0);
    end
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(1);

    // Take and mispredict together with two outstanding.
    nx_regs[5] = 32'hC1;
    step(1, 0, 0, 0, 0);
    nx_regs[5] = 32'hC2;
    step(1, 0, 0, 0, 0);
    nx_regs[5] = 32'hC3;
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(1);

    // Write-back bypass on r7, then a write-back to r0.
    nx_regs[7] = 32'h11; nx_wbu = 1'b1; nx_wa = 5'd7; nx_wd = 32'h55;
    step(1, 0, 0, 0, 0);
    nx_regs[0] = 32'h0; nx_wa = 5'd0; nx_wd = 32'h99;
    step(1, 0, 0, 0, 0);
    nx_wbu = 1'b0;
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    idle(1);

    // Reset while waiting for done; the late done must be ignored.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 32; i++) nx_regs[i] = $urandom;
      nx_wbu = ($urandom_range(0, 1) == 1);
      nx_wa  = 5'($urandom_range(0, 31));
      nx_wd  = $urandom;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(3);
    check("pending_restores", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
